// File: rtl/ysyx_23060184_hazard_scoreboard_pkg.sv
// Shared register-file geometry and scoreboard defaults used by the decode-side hazard logic.
package ysyx_23060184_hazard_scoreboard_pkg;

  localparam int REG_IDX_W        = 5;
  localparam int NUM_REGS         = 32;
  localparam int MAX_INFLIGHT_DEF = 4;
  localparam int INFLIGHT_W       = 3;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/ysyx_23060184_hazard_scoreboard.sv
// Per-register pending-write scoreboard: stalls decode on RAW/WAW-saturation, in-flight limit
// and serializing instructions; tracks issue/retire counts and flags retire underflow.
module ysyx_23060184_hazard_scoreboard
  import ysyx_23060184_hazard_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int CNT_W        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic                  ex_ready,
  input  logic [REG_IDX_W-1:0]  dec_rs1,
  input  logic [REG_IDX_W-1:0]  dec_rs2,
  input  logic                  dec_rs2_valid,
  input  logic [REG_IDX_W-1:0]  dec_rd,
  input  logic                  dec_regwrite,
  input  logic                  dec_serialize,
  input  logic                  wb_valid,
  input  logic [REG_IDX_W-1:0]  wb_rd,
  input  logic                  wb_regwrite,
  output logic                  stall,
  output logic                  issue,
  output logic [NUM_REGS-1:0]   busy,
  output logic [INFLIGHT_W-1:0] inflight,
  output logic                  err
);

  localparam logic [CNT_W-1:0]      CNT_SAT      = '1;
  localparam logic [INFLIGHT_W-1:0] INFLIGHT_MAX = INFLIGHT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0]      cnt [NUM_REGS];
  logic [INFLIGHT_W-1:0] inflight_q;
  logic                  err_q;

  logic haz_rs1, haz_rs2, haz_rd, haz_ser;
  logic inc, retire_req, retire_bad, retire_ok;

  always_comb begin
    busy = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      busy[i] = (cnt[i] != '0);
    end
  end

  // Hazards look only at registered state, so a retire this cycle cannot unblock decode yet.
  always_comb begin
    haz_rs1 = (dec_rs1 != '0) && busy[dec_rs1];
    haz_rs2 = dec_rs2_valid && (dec_rs2 != '0) && busy[dec_rs2];
    haz_rd  = dec_regwrite &&
              (((dec_rd != '0) && (cnt[dec_rd] == CNT_SAT)) || (inflight_q == INFLIGHT_MAX));
    haz_ser = dec_serialize && (inflight_q != '0);
    stall   = dec_valid && (haz_rs1 || haz_rs2 || haz_rd || haz_ser);
    issue   = dec_valid && ex_ready && !stall && !rst;
  end

  always_comb begin
    inc        = issue && dec_regwrite && (dec_rd != '0);
    retire_req = wb_valid && wb_regwrite && (wb_rd != '0);
    retire_bad = (cnt[wb_rd] == '0) || (inflight_q == '0);
    retire_ok  = retire_req && !retire_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= '0;
      end
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (inc && (dec_rd == REG_IDX_W'(i)) && !(retire_ok && (wb_rd == REG_IDX_W'(i)))) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (retire_ok && (wb_rd == REG_IDX_W'(i)) && !(inc && (dec_rd == REG_IDX_W'(i)))) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
      if (inc && !retire_ok) begin
        inflight_q <= inflight_q + INFLIGHT_W'(1);
      end else if (!inc && retire_ok) begin
        inflight_q <= inflight_q - INFLIGHT_W'(1);
      end
      // An underflowing retire is dropped and latched as a protocol error until reset.
      if (retire_req && retire_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign inflight = inflight_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ysyx_23060184_hazard_scoreboard.sv
// Directed bench for the hazard scoreboard with hand-computed expectations.
module tb_ysyx_23060184_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, ex_ready, dec_rs2_valid, dec_regwrite, dec_serialize;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic        wb_valid, wb_regwrite;
  logic        stall, issue, err;
  logic [31:0] busy;
  logic [2:0]  inflight;

  int total = 0;
  int bad   = 0;

  ysyx_23060184_hazard_scoreboard dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .ex_ready(ex_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs2_valid(dec_rs2_valid),
    .dec_rd(dec_rd), .dec_regwrite(dec_regwrite), .dec_serialize(dec_serialize),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .stall(stall), .issue(issue), .busy(busy), .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic rdy, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic rs2v, input logic [4:0] rd, input logic rw, input logic ser);
    dec_valid = v; ex_ready = rdy; dec_rs1 = rs1; dec_rs2 = rs2;
    dec_rs2_valid = rs2v; dec_rd = rd; dec_regwrite = rw; dec_serialize = ser;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic rw);
    wb_valid = v; wb_rd = rd; wb_regwrite = rw;
    #1;
  endtask

  task automatic idle();
    set_dec(0, 1, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
  endtask

  // Issue a plain register-writing instruction to rd and advance one cycle.
  task automatic issue_rd(input logic [4:0] rd);
    set_dec(1, 1, 0, 0, 0, rd, 1, 0);
    set_wb(0, 0, 0);
    tick();
  endtask

  task automatic retire_rd(input logic [4:0] rd);
    set_dec(0, 1, 0, 0, 0, 0, 0, 0);
    set_wb(1, rd, 1);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    idle();
    chk("rst_busy", busy, 32'h0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // RAW on x5, no bypass from a same-cycle retire
    set_dec(1, 1, 1, 0, 0, 5, 1, 0);
    set_wb(0, 0, 0);
    chk("raw_first_issue", 32'(issue), 32'd1);
    tick();
    set_dec(1, 1, 5, 0, 0, 6, 1, 0);
    set_wb(1, 5, 1);
    chk("raw_stall", 32'(stall), 32'd1);
    chk("raw_no_issue", 32'(issue), 32'd0);
    chk("raw_busy5", busy, 32'h0000_0020);
    chk("raw_inflight1", 32'(inflight), 32'd1);
    tick();
    set_wb(0, 0, 0);
    chk("raw_cleared_stall", 32'(stall), 32'd0);
    chk("raw_cleared_issue", 32'(issue), 32'd1);
    chk("raw_cleared_busy", busy, 32'h0);
    tick();
    chk("raw_busy6", busy, 32'h0000_0040);
    retire_rd(6);
    chk("raw_drain", 32'(inflight), 32'd0);

    // rs2 hazard only when rs2 is a real operand
    issue_rd(8);
    set_dec(1, 1, 0, 8, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    chk("rs2_invalid_nostall", 32'(stall), 32'd0);
    set_dec(1, 1, 0, 8, 1, 0, 0, 0);
    set_wb(0, 0, 0);
    chk("rs2_valid_stall", 32'(stall), 32'd1);
    retire_rd(8);

    // counter saturation on x7
    issue_rd(7);
    issue_rd(7);
    issue_rd(7);
    chk("sat_inflight3", 32'(inflight), 32'd3);
    set_dec(1, 1, 0, 0, 0, 7, 1, 0);
    set_wb(1, 7, 1);
    chk("sat_stall", 32'(stall), 32'd1);
    tick();
    set_wb(0, 0, 0);
    chk("sat_after_retire_issue", 32'(issue), 32'd1);
    tick();
    chk("sat_inflight_again3", 32'(inflight), 32'd3);
    set_dec(1, 1, 0, 0, 0, 7, 1, 0);
    set_wb(0, 0, 0);
    chk("sat_cnt7_is3", 32'(stall), 32'd1);
    retire_rd(7);
    retire_rd(7);
    chk("sat_busy7_still", busy, 32'h0000_0080);
    retire_rd(7);
    chk("sat_busy_clear", busy, 32'h0);
    chk("sat_inflight0", 32'(inflight), 32'd0);

    // same-cycle issue and retire of x9
    issue_rd(9);
    set_dec(1, 1, 0, 0, 0, 9, 1, 0);
    set_wb(1, 9, 1);
    chk("same_issue", 32'(issue), 32'd1);
    tick();
    chk("same_busy9", busy, 32'h0000_0200);
    chk("same_inflight", 32'(inflight), 32'd1);
    retire_rd(9);
    chk("same_cnt9_was1", busy, 32'h0);
    chk("same_no_err", 32'(err), 32'd0);

    // in-flight limit
    issue_rd(1);
    issue_rd(2);
    issue_rd(3);
    issue_rd(4);
    chk("lim_inflight4", 32'(inflight), 32'd4);
    chk("lim_busy", busy, 32'h0000_001E);
    set_dec(1, 1, 0, 0, 0, 10, 1, 0);
    set_wb(0, 0, 0);
    chk("lim_write_stall", 32'(stall), 32'd1);
    set_dec(1, 0, 0, 0, 0, 10, 1, 0);
    set_wb(0, 0, 0);
    chk("lim_stall_indep_ready", 32'(stall), 32'd1);
    set_dec(1, 0, 0, 0, 0, 10, 0, 0);
    set_wb(0, 0, 0);
    chk("lim_not_ready_noissue", 32'(issue), 32'd0);
    set_dec(1, 1, 0, 0, 0, 10, 0, 0);
    set_wb(0, 0, 0);
    chk("lim_nowrite_issue", 32'(issue), 32'd1);
    tick();
    chk("lim_inflight_kept", 32'(inflight), 32'd4);
    retire_rd(1);
    retire_rd(2);
    chk("lim_inflight2", 32'(inflight), 32'd2);

    // serialize waits for an empty pipeline
    set_dec(1, 1, 0, 0, 0, 0, 0, 1);
    set_wb(1, 3, 1);
    chk("ser_stall_2", 32'(stall), 32'd1);
    tick();
    set_wb(1, 4, 1);
    chk("ser_stall_1", 32'(stall), 32'd1);
    tick();
    set_wb(0, 0, 0);
    chk("ser_issue", 32'(issue), 32'd1);
    chk("ser_inflight0", 32'(inflight), 32'd0);
    tick();
    issue_rd(0);
    chk("rd0_busy", busy, 32'h0);
    chk("rd0_inflight", 32'(inflight), 32'd0);

    // retire underflow is sticky; reset clears everything
    retire_rd(3);
    chk("err_set", 32'(err), 32'd1);
    chk("err_inflight_held", 32'(inflight), 32'd0);
    idle();
    tick();
    tick();
    chk("err_sticky", 32'(err), 32'd1);
    issue_rd(12);
    issue_rd(13);
    chk("pre_rst_busy", busy, 32'h0000_3000);
    rst = 1'b1;
    set_dec(1, 1, 0, 0, 0, 14, 1, 0);
    set_wb(1, 12, 1);
    chk("rst_masks_issue", 32'(issue), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    chk("post_rst_busy", busy, 32'h0);
    chk("post_rst_inflight", 32'(inflight), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);

    // retire of an idle register while other writes are pending
    issue_rd(2);
    retire_rd(8);
    chk("idle_reg_err", 32'(err), 32'd1);
    chk("idle_reg_inflight", 32'(inflight), 32'd1);
    chk("idle_reg_busy", busy, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
